// File: rtl/lcd_hd44780_rx.sv
// Receiving side of an HD44780 4-bit LCD bus. It samples RS, EN and DB7..DB4, runs the
// 8->4-bit init handshake, assembles bytes, decodes instructions and keeps a 16x2 DDRAM image.
module lcd_hd44780_rx #(
  parameter int unsigned BUSY_SHORT = 4625,
  parameter int unsigned BUSY_LONG  = 190000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       mode_4bit,
  output logic       disp_on,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       err_busy,
  output logic       err_proto
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [1:0] {M8, M4_HI, M4_LO} rx_state_t;

  rx_state_t      state;
  logic           en_q, rs_q;
  logic [3:0]     data_q;
  logic [3:0]     hi_nib;
  logic           hi_rs;
  logic           inc_dir;
  logic [CW-1:0]  busy_cnt;
  logic [7:0]     ddram [32];

  logic           strobe, accept, proto_bad;
  logic [7:0]     acc_byte;
  logic           acc_rs;
  logic           is_cmd, is_addr, is_fset, is_disp, is_entry, is_home, is_clear, is_data;
  logic           cell_hit;
  logic [4:0]     cell_idx;

  // Line 1 DDRAM addresses 0x00-0x0F and line 2 addresses 0x40-0x4F are the visible cells.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      case (a)
        7'h27:   return 7'h40;
        7'h67:   return 7'h00;
        default: return a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h40:   return 7'h27;
        7'h00:   return 7'h67;
        default: return a - 7'd1;
      endcase
    end
  endfunction

  assign strobe  = en_q & ~lcd_en;
  assign busy    = (busy_cnt != '0);
  assign rd_char = ddram[rd_addr];

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    accept    = 1'b0;
    proto_bad = 1'b0;
    acc_byte  = {data_q, 4'h0};
    acc_rs    = rs_q;
    if (strobe) begin
      case (state)
        M8:    accept = 1'b1;
        M4_LO: begin
          if (rs_q == hi_rs) begin
            accept   = 1'b1;
            acc_byte = {hi_nib, data_q};
            acc_rs   = hi_rs;
          end else begin
            proto_bad = 1'b1;
          end
        end
        default: accept = 1'b0;
      endcase
    end
  end

  always_comb begin
    is_cmd   = accept & ~acc_rs;
    is_data  = accept & acc_rs;
    is_addr  = is_cmd & acc_byte[7];
    is_fset  = is_cmd & (acc_byte[7:5] == 3'b001);
    is_disp  = is_cmd & (acc_byte[7:3] == 5'b00001);
    is_entry = is_cmd & (acc_byte[7:2] == 6'b000001);
    is_home  = is_cmd & (acc_byte[7:1] == 7'b0000001);
    is_clear = is_cmd & (acc_byte == 8'h01);
    cell_hit = (cursor_addr[6:4] == 3'b000) || (cursor_addr[6:4] == 3'b100);
    cell_idx = {cursor_addr[6], cursor_addr[3:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    en_q   <= lcd_en;
    rs_q   <= lcd_rs;
    data_q <= lcd_data;
    if (RST) begin
      state       <= M8;
      mode_4bit   <= 1'b0;
      hi_nib      <= 4'h0;
      hi_rs       <= 1'b0;
      inc_dir     <= 1'b1;
      disp_on     <= 1'b0;
      cursor_addr <= 7'h00;
      busy_cnt    <= '0;
      byte_valid  <= 1'b0;
      byte_out    <= 8'h00;
      byte_rs     <= 1'b0;
      err_busy    <= 1'b0;
      err_proto   <= 1'b0;
      // NOTE: the DDRAM image is a register array so it can be reset to blanks like any flop.
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
    end else begin
      byte_valid <= accept;
      err_busy   <= strobe & busy;
      err_proto  <= proto_bad;
      if (accept) begin
        byte_out <= acc_byte;
        byte_rs  <= acc_rs;
      end

      if (strobe) begin
        case (state)
          M4_HI: begin
            hi_nib <= data_q;
            hi_rs  <= rs_q;
            state  <= M4_LO;
          end
          M4_LO:   state <= M4_HI;
          default: state <= M8;
        endcase
      end
      if (is_fset) begin
        state     <= acc_byte[4] ? M8 : M4_HI;
        mode_4bit <= ~acc_byte[4];
      end

      if (accept)
        busy_cnt <= (is_home | is_clear) ? CW'(BUSY_LONG) : CW'(BUSY_SHORT);
      else if (busy)
        busy_cnt <= busy_cnt - CW'(1);

      if (is_disp)  disp_on <= acc_byte[2];
      if (is_entry) inc_dir <= acc_byte[1];
      else if (is_clear) inc_dir <= 1'b1;

      if (is_addr)
        cursor_addr <= acc_byte[6:0];
      else if (is_home | is_clear)
        cursor_addr <= 7'h00;
      else if (is_data)
        cursor_addr <= step_addr(cursor_addr, inc_dir);

      if (is_clear)
        for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      else if (is_data && cell_hit)
        ddram[cell_idx] <= acc_byte;
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Scoreboard bench for lcd_hd44780_rx: expected bytes are queued as nibbles are driven and
// popped when byte_valid fires; each scenario task checks its own DDRAM/status results.
module tb_lcd_hd44780_rx;

  // Scaled-down busy times keep the run short while exercising the same behaviour.
  localparam int BS  = 46;
  localparam int BL  = 1900;
  localparam int GAP = BS + 14;
  localparam int LGAP = BL + 150;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] lcd_data = 4'h0;
  logic       lcd_rs = 1'b0;
  logic       lcd_en = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_rs;
  logic       mode_4bit;
  logic       disp_on;
  logic [6:0] cursor_addr;
  logic       busy;
  logic       err_busy;
  logic       err_proto;

  int checks = 0;
  int errors = 0;
  int n_err_busy = 0;
  int n_err_proto = 0;
  logic [8:0] exp_q [$];

  lcd_hd44780_rx #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .CLK(CLK), .RST(RST), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_en(lcd_en),
    .rd_addr(rd_addr), .rd_char(rd_char), .byte_valid(byte_valid), .byte_out(byte_out),
    .byte_rs(byte_rs), .mode_4bit(mode_4bit), .disp_on(disp_on), .cursor_addr(cursor_addr),
    .busy(busy), .err_busy(err_busy), .err_proto(err_proto)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge CLK);
      if (err_busy)  n_err_busy++;
      if (err_proto) n_err_proto++;
      if (byte_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got rs=%0b byte=%h want none", byte_rs, byte_out);
        end else begin
          e = exp_q.pop_front();
          if ({byte_rs, byte_out} !== e) begin
            errors++;
            $display("FAIL sb_byte got rs=%0b byte=%h want rs=%0b byte=%h",
                     byte_rs, byte_out, e[8], e[7:0]);
          end
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_nib(input logic rs, input logic [3:0] nib);
    @(posedge CLK); #1;
    lcd_rs = rs; lcd_data = nib; lcd_en = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    lcd_en = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b});
    send_nib(rs, b[7:4]);
    send_nib(rs, b[3:0]);
  endtask

  task automatic do_reset();
    RST = 1'b1; lcd_en = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge CLK);
    while (busy && n < 5000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    checks++;
    if ({mode_4bit, disp_on, busy, byte_valid, byte_rs, err_busy, err_proto} !== 7'b0 ||
        byte_out !== 8'h00 || cursor_addr !== 7'h00) begin
      errors++;
      $display("FAIL reset_state got m4=%0b don=%0b busy=%0b bv=%0b brs=%0b bo=%h ca=%h want all 0",
               mode_4bit, disp_on, busy, byte_valid, byte_rs, byte_out, cursor_addr);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      if (rd_char !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_ddram got %0d non-blank cells want 0", bad);
    end
  endtask

  task automatic test_init_8bit();
    logic [3:0] nibs [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, nibs[i], 4'h0});
      send_nib(1'b0, nibs[i]);
      if (i == 2) begin
        checks++;
        if (mode_4bit !== 1'b0) begin
          errors++;
          $display("FAIL t1_mode_after_3 got %0b want 0", mode_4bit);
        end
      end
      wait_cyc(GAP);
    end
    checks++;
    if (mode_4bit !== 1'b1) begin
      errors++;
      $display("FAIL t1_mode_4bit got %0b want 1", mode_4bit);
    end
    checks++;
    if (n_err_busy != 0 || n_err_proto != 0) begin
      errors++;
      $display("FAIL t1_no_err got busy=%0d proto=%0d want 0 0", n_err_busy, n_err_proto);
    end
  endtask

  task automatic test_config();
    int n, bad;
    send_byte(1'b0, 8'h28); wait_cyc(GAP);
    send_byte(1'b0, 8'h0E); wait_cyc(GAP);
    send_byte(1'b0, 8'h06); wait_cyc(GAP);
    send_byte(1'b0, 8'h01);
    count_busy(n);
    checks++;
    if (n != BL) begin
      errors++;
      $display("FAIL t2_busy_long got %0d cycles want %0d", n, BL);
    end
    wait_cyc(LGAP - BL);
    checks++;
    if (disp_on !== 1'b1 || cursor_addr !== 7'h00 || mode_4bit !== 1'b1) begin
      errors++;
      $display("FAIL t2_status got don=%0b ca=%h m4=%0b want 1 00 1", disp_on, cursor_addr, mode_4bit);
    end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      if (rd_char !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL t2_cleared got %0d non-blank cells want 0", bad);
    end
  endtask

  task automatic test_data();
    logic [7:0] txt [6] = '{8'h46, 8'h55, 8'h52, 8'h4B, 8'h41, 8'h4E};
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b1, txt[i]);
      wait_cyc(GAP);
    end
    for (int i = 0; i < 6; i++) begin
      rd_addr = 5'(i); #1;
      checks++;
      if (rd_char !== txt[i]) begin
        errors++;
        $display("FAIL t3_char%0d got %h want %h", i, rd_char, txt[i]);
      end
    end
    checks++;
    if (cursor_addr !== 7'h06) begin
      errors++;
      $display("FAIL t3_cursor got %h want 06", cursor_addr);
    end
  endtask

  task automatic test_addr_wrap();
    send_byte(1'b0, 8'h8F); wait_cyc(GAP);
    send_byte(1'b1, 8'h41); wait_cyc(GAP);
    send_byte(1'b1, 8'h42); wait_cyc(GAP);
    rd_addr = 5'd15; #1;
    checks++;
    if (rd_char !== 8'h41) begin
      errors++;
      $display("FAIL t4_idx15 got %h want 41", rd_char);
    end
    rd_addr = 5'd16; #1;
    checks++;
    if (rd_char !== 8'h20 || cursor_addr !== 7'h11) begin
      errors++;
      $display("FAIL t4_offscreen got idx16=%h ca=%h want 20 11", rd_char, cursor_addr);
    end
    send_byte(1'b0, 8'hA7); wait_cyc(GAP);
    send_byte(1'b1, 8'h43); wait_cyc(GAP);
    checks++;
    if (cursor_addr !== 7'h40) begin
      errors++;
      $display("FAIL t4_wrap_27 got %h want 40", cursor_addr);
    end
    send_byte(1'b0, 8'hE7); wait_cyc(GAP);
    send_byte(1'b1, 8'h44); wait_cyc(GAP);
    rd_addr = 5'd31; #1;
    checks++;
    if (rd_char !== 8'h20 || cursor_addr !== 7'h00) begin
      errors++;
      $display("FAIL t4_wrap_67 got idx31=%h ca=%h want 20 00", rd_char, cursor_addr);
    end
    // Decrement mode: writing at 0x00 steps back to 0x67.
    send_byte(1'b0, 8'h04); wait_cyc(GAP);
    send_byte(1'b0, 8'h80); wait_cyc(GAP);
    send_byte(1'b1, 8'h5A); wait_cyc(GAP);
    rd_addr = 5'd0; #1;
    checks++;
    if (rd_char !== 8'h5A || cursor_addr !== 7'h67) begin
      errors++;
      $display("FAIL t4_decrement got idx0=%h ca=%h want 5a 67", rd_char, cursor_addr);
    end
    send_byte(1'b0, 8'h06); wait_cyc(GAP);
    send_byte(1'b0, 8'h02); wait_cyc(LGAP);
    checks++;
    if (cursor_addr !== 7'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_home got ca=%h busy=%0b want 00 0", cursor_addr, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n, eb0;
    send_byte(1'b0, 8'h80); wait_cyc(GAP);
    send_byte(1'b1, 8'h31);
    wait_cyc(10);
    eb0 = n_err_busy;
    send_byte(1'b1, 8'h32);
    count_busy(n);
    checks++;
    if (n != BS) begin
      errors++;
      $display("FAIL t5_reload got %0d busy cycles want %0d", n, BS);
    end
    checks++;
    if (n_err_busy - eb0 != 2) begin
      errors++;
      $display("FAIL t5_err_busy got %0d pulses want 2", n_err_busy - eb0);
    end
    rd_addr = 5'd1; #1;
    checks++;
    if (rd_char !== 8'h32) begin
      errors++;
      $display("FAIL t5_stored got %h want 32", rd_char);
    end
    wait_cyc(GAP);
  endtask

  task automatic test_proto();
    int ep0;
    ep0 = n_err_proto;
    send_nib(1'b1, 4'h4);
    send_nib(1'b0, 4'h1);
    wait_cyc(GAP);
    checks++;
    if (n_err_proto - ep0 != 1) begin
      errors++;
      $display("FAIL t6_err_proto got %0d pulses want 1", n_err_proto - ep0);
    end
    send_byte(1'b1, 8'h58); wait_cyc(GAP);
    rd_addr = 5'd2; #1;
    checks++;
    if (rd_char !== 8'h58) begin
      errors++;
      $display("FAIL t6_recover got %h want 58", rd_char);
    end
    send_nib(1'b0, 4'h4);
    wait_cyc(3);
    do_reset();
    checks++;
    if (mode_4bit !== 1'b0) begin
      errors++;
      $display("FAIL t6_rst_mode got %0b want 0", mode_4bit);
    end
    exp_q.push_back({1'b1, 8'h70});
    send_nib(1'b1, 4'h7);
    wait_cyc(4);
    rd_addr = 5'd0; #1;
    checks++;
    if (rd_char !== 8'h70 || cursor_addr !== 7'h01 || mode_4bit !== 1'b0) begin
      errors++;
      $display("FAIL t6_8bit_after_rst got idx0=%h ca=%h m4=%0b want 70 01 0",
               rd_char, cursor_addr, mode_4bit);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_init_8bit();
    test_config();
    test_data();
    test_addr_wrap();
    test_back_to_back();
    test_proto();
    wait_cyc(GAP);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d bytes pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
